// File: rtl/hazard_flush_controller_if.sv
// Bundle of the decode/execute/memory control signals seen by the hazard
// and flush controller.
//   master : pipeline side, drives stage status and consumes the controls.
//   slave  : controller side, consumes stage status and drives redirect,
//            flush, stall, forwarding selects and event counters.
interface hazard_flush_controller_if #(
   parameter int REGISTER_WIDTH = 32
);
   logic                      dec_valid;
   logic [4:0]                dec_rs1;
   logic [4:0]                dec_rs2;
   logic                      dec_uses_rs1;
   logic                      dec_uses_rs2;
   logic                      ex_valid;
   logic                      ex_ready;
   logic [4:0]                ex_rd;
   logic                      ex_reg_write;
   logic                      ex_is_load;
   logic                      ex_branch_taken;
   logic [REGISTER_WIDTH-1:0] ex_branch_target;
   logic                      mem_valid;
   logic [4:0]                mem_rd;
   logic                      mem_reg_write;
   logic                      redirect_valid;
   logic [REGISTER_WIDTH-1:0] redirect_target;
   logic                      flush_fetch;
   logic                      flush_decode;
   logic                      stall_decode;
   logic [1:0]                fwd_rs1_sel;
   logic [1:0]                fwd_rs2_sel;
   logic [REGISTER_WIDTH-1:0] stall_count;
   logic [REGISTER_WIDTH-1:0] flush_count;

   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
             ex_valid, ex_ready, ex_rd, ex_reg_write, ex_is_load,
             ex_branch_taken, ex_branch_target,
             mem_valid, mem_rd, mem_reg_write,
      input  redirect_valid, redirect_target, flush_fetch, flush_decode,
             stall_decode, fwd_rs1_sel, fwd_rs2_sel, stall_count, flush_count
   );

   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
             ex_valid, ex_ready, ex_rd, ex_reg_write, ex_is_load,
             ex_branch_taken, ex_branch_target,
             mem_valid, mem_rd, mem_reg_write,
      output redirect_valid, redirect_target, flush_fetch, flush_decode,
             stall_decode, fwd_rs1_sel, fwd_rs2_sel, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_flush_controller.sv
// Pipeline hazard and flush controller around the execute stage.
// - Load-use hazards stall decode (same cycle, LOAD_LATENCY cycles total).
// - A taken branch/jump firing in execute produces a registered one-cycle
//   PC redirect and FLUSH_CYCLES cycles of fetch/decode flush.
// - Combinational operand-forwarding selects (0 regfile, 1 ex, 2 mem).
// - Saturating stall-cycle and redirect counters.
// Ports: clk, rst (async, active high), bus (slave side of
// hazard_flush_controller_if carrying all stage status and controls).
module hazard_flush_controller #(
   parameter int REGISTER_WIDTH = 32,
   parameter int FLUSH_CYCLES   = 2,
   parameter int LOAD_LATENCY   = 1
) (
   input logic                     clk,
   input logic                     rst,
   hazard_flush_controller_if.slave bus
);
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
   localparam logic [3:0] STALL_INIT = 4'(LOAD_LATENCY - 1);
   localparam logic [REGISTER_WIDTH-1:0] COUNT_MAX = '1;

   state_t                    state_r;
   state_t                    state_next_s;
   logic [3:0]                cnt_r;
   logic [3:0]                cnt_next_s;
   logic                      ex_fire_s;
   logic                      hazard_s;
   logic                      take_s;
   logic                      stall_s;
   logic                      ex_fwd_ok_s;
   logic                      mem_fwd_ok_s;
   logic                      redirect_valid_r;
   logic [REGISTER_WIDTH-1:0] redirect_target_r;
   logic                      flush_r;
   logic [REGISTER_WIDTH-1:0] stall_count_r;
   logic [REGISTER_WIDTH-1:0] flush_count_r;

   // True when an operand that is actually read names the given register.
   function automatic logic reads_reg(input logic uses, input logic [4:0] rs,
                                      input logic [4:0] rd);
      return uses && (rs == rd);
   endfunction

   // Forwarding select for one source; execute beats memory, x0 never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic ex_ok, input logic [4:0] ex_rd,
                                          input logic mem_ok, input logic [4:0] mem_rd);
      logic [1:0] sel;
      if (ex_ok && (ex_rd != 5'd0) && (ex_rd == rs)) begin
         sel = 2'd1;
      end else if (mem_ok && (mem_rd != 5'd0) && (mem_rd == rs)) begin
         sel = 2'd2;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction

   assign ex_fire_s    = bus.ex_valid & bus.ex_ready;
   // A load result is not available in execute, so it only forwards from memory.
   assign ex_fwd_ok_s  = bus.ex_valid & bus.ex_reg_write & ~bus.ex_is_load;
   assign mem_fwd_ok_s = bus.mem_valid & bus.mem_reg_write;
   assign hazard_s     = bus.dec_valid & bus.ex_valid & bus.ex_is_load &
                         bus.ex_reg_write & (bus.ex_rd != 5'd0) &
                         (reads_reg(bus.dec_uses_rs1, bus.dec_rs1, bus.ex_rd) |
                          reads_reg(bus.dec_uses_rs2, bus.dec_rs2, bus.ex_rd));

   // Next-state, shared countdown and per-cycle redirect/stall decisions.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      take_s       = 1'b0;
      stall_s      = 1'b0;
      case (state_r)
         RUN: begin
            if (ex_fire_s && bus.ex_branch_taken) begin
               take_s       = 1'b1;
               state_next_s = FLUSH;
               cnt_next_s   = FLUSH_INIT;
            end else if (hazard_s) begin
               stall_s = 1'b1;
               // The hazard cycle itself is the first stall cycle.
               if (LOAD_LATENCY > 1) begin
                  state_next_s = STALL;
                  cnt_next_s   = STALL_INIT;
               end else begin
                  state_next_s = RUN;
               end
            end else begin
               state_next_s = RUN;
            end
         end
         FLUSH: begin
            // Branches here are wrong-path and hazards are masked.
            if (cnt_r == 4'd0) begin
               state_next_s = RUN;
            end else begin
               cnt_next_s = cnt_r - 4'd1;
            end
         end
         STALL: begin
            if (ex_fire_s && bus.ex_branch_taken) begin
               take_s       = 1'b1;
               state_next_s = FLUSH;
               cnt_next_s   = FLUSH_INIT;
            end else begin
               // cnt holds the stall cycles still owed, this one included.
               stall_s    = 1'b1;
               cnt_next_s = cnt_r - 4'd1;
               if (cnt_r <= 4'd1) begin
                  state_next_s = RUN;
               end else begin
                  state_next_s = STALL;
               end
            end
         end
         default: begin
            state_next_s = RUN;
            cnt_next_s   = 4'd0;
         end
      endcase
   end

   // State, registered redirect/flush outputs and saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r           <= RUN;
         cnt_r             <= 4'd0;
         redirect_valid_r  <= 1'b0;
         redirect_target_r <= '0;
         flush_r           <= 1'b0;
         stall_count_r     <= '0;
         flush_count_r     <= '0;
      end else begin
         state_r          <= state_next_s;
         cnt_r            <= cnt_next_s;
         redirect_valid_r <= take_s;
         flush_r          <= (state_next_s == FLUSH);
         if (take_s) begin
            redirect_target_r <= bus.ex_branch_target;
         end
         if (stall_s && (stall_count_r != COUNT_MAX)) begin
            stall_count_r <= stall_count_r + 1'b1;
         end
         if (take_s && (flush_count_r != COUNT_MAX)) begin
            flush_count_r <= flush_count_r + 1'b1;
         end
      end
   end

   assign bus.redirect_valid  = redirect_valid_r;
   assign bus.redirect_target = redirect_target_r;
   assign bus.flush_fetch     = flush_r;
   assign bus.flush_decode    = flush_r;
   assign bus.stall_decode    = stall_s;
   assign bus.fwd_rs1_sel     = fwd_sel(bus.dec_rs1, ex_fwd_ok_s, bus.ex_rd,
                                        mem_fwd_ok_s, bus.mem_rd);
   assign bus.fwd_rs2_sel     = fwd_sel(bus.dec_rs2, ex_fwd_ok_s, bus.ex_rd,
                                        mem_fwd_ok_s, bus.mem_rd);
   assign bus.stall_count     = stall_count_r;
   assign bus.flush_count     = flush_count_r;
endmodule

// File: tb/tb_hazard_flush_controller.sv
module tb_hazard_flush_controller;
   localparam int RW = 32;
   localparam int FC = 2;
   localparam int LL = 3;

   typedef struct packed {
      logic        dec_valid;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        use1;
      logic        use2;
      logic        ex_valid;
      logic        ex_ready;
      logic [4:0]  ex_rd;
      logic        ex_wr;
      logic        ex_load;
      logic        ex_taken;
      logic [31:0] target;
      logic        mem_valid;
      logic [4:0]  mem_rd;
      logic        mem_wr;
   } in_t;

   typedef struct {
      in_t        in;
      logic [1:0] f1;
      logic [1:0] f2;
      logic       st;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_flush_controller_if #(.REGISTER_WIDTH(RW)) bus ();
   hazard_flush_controller_if #(.REGISTER_WIDTH(8))  bus8 ();

   hazard_flush_controller #(.REGISTER_WIDTH(RW), .FLUSH_CYCLES(FC), .LOAD_LATENCY(LL))
      dut (.clk(clk), .rst(rst), .bus(bus));
   hazard_flush_controller #(.REGISTER_WIDTH(8), .FLUSH_CYCLES(FC), .LOAD_LATENCY(LL))
      dut8 (.clk(clk), .rst(rst), .bus(bus8));

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: cycles of flush / extra stall still owed.
   int          m_flush_left;
   int          m_stall_left;
   logic        m_redir;
   logic [31:0] m_target;
   logic [31:0] m_fcnt;
   logic [31:0] m_scnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [1:0] ref_fwd(input in_t v, input logic [4:0] rs);
      if (v.ex_valid && v.ex_wr && !v.ex_load && v.ex_rd != 5'd0 && v.ex_rd == rs) return 2'd1;
      if (v.mem_valid && v.mem_wr && v.mem_rd != 5'd0 && v.mem_rd == rs) return 2'd2;
      return 2'd0;
   endfunction

   function automatic in_t fv(input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                              input logic u1, input logic u2, input logic exv,
                              input logic [4:0] exrd, input logic exwr, input logic exld,
                              input logic memv, input logic [4:0] memrd, input logic memwr);
      in_t v;
      v = '0;
      v.dec_valid = dv;   v.rs1 = r1;     v.rs2 = r2;   v.use1 = u1; v.use2 = u2;
      v.ex_valid = exv;   v.ex_ready = 1'b1; v.ex_rd = exrd; v.ex_wr = exwr; v.ex_load = exld;
      v.mem_valid = memv; v.mem_rd = memrd; v.mem_wr = memwr;
      return v;
   endfunction

   task automatic drive(input in_t v);
      bus.dec_valid = v.dec_valid;        bus.dec_rs1 = v.rs1;         bus.dec_rs2 = v.rs2;
      bus.dec_uses_rs1 = v.use1;          bus.dec_uses_rs2 = v.use2;
      bus.ex_valid = v.ex_valid;          bus.ex_ready = v.ex_ready;   bus.ex_rd = v.ex_rd;
      bus.ex_reg_write = v.ex_wr;         bus.ex_is_load = v.ex_load;
      bus.ex_branch_taken = v.ex_taken;   bus.ex_branch_target = v.target;
      bus.mem_valid = v.mem_valid;        bus.mem_rd = v.mem_rd;       bus.mem_reg_write = v.mem_wr;
   endtask

   task automatic drive8(input in_t v);
      bus8.dec_valid = v.dec_valid;       bus8.dec_rs1 = v.rs1;        bus8.dec_rs2 = v.rs2;
      bus8.dec_uses_rs1 = v.use1;         bus8.dec_uses_rs2 = v.use2;
      bus8.ex_valid = v.ex_valid;         bus8.ex_ready = v.ex_ready;  bus8.ex_rd = v.ex_rd;
      bus8.ex_reg_write = v.ex_wr;        bus8.ex_is_load = v.ex_load;
      bus8.ex_branch_taken = v.ex_taken;  bus8.ex_branch_target = v.target[7:0];
      bus8.mem_valid = v.mem_valid;       bus8.mem_rd = v.mem_rd;      bus8.mem_reg_write = v.mem_wr;
   endtask

   task automatic model_reset();
      m_flush_left = 0; m_stall_left = 0; m_redir = 1'b0;
      m_target = 32'd0; m_fcnt = 32'd0; m_scnt = 32'd0;
   endtask

   // One clock cycle starting at a negedge: drive, compare against model, advance.
   task automatic step(input in_t v);
      logic take, hz, es;
      drive(v);
      #1;
      take = v.ex_valid && v.ex_ready && v.ex_taken && (m_flush_left == 0);
      hz   = v.dec_valid && v.ex_valid && v.ex_load && v.ex_wr && (v.ex_rd != 5'd0) &&
             ((v.use1 && v.rs1 == v.ex_rd) || (v.use2 && v.rs2 == v.ex_rd));
      es   = !take && (m_flush_left == 0) && ((m_stall_left > 0) || hz);
      chk("stall_decode", 32'(bus.stall_decode), 32'(es));
      chk("fwd_rs1_sel", 32'(bus.fwd_rs1_sel), 32'(ref_fwd(v, v.rs1)));
      chk("fwd_rs2_sel", 32'(bus.fwd_rs2_sel), 32'(ref_fwd(v, v.rs2)));
      chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_redir));
      if (m_redir) chk("redirect_target", bus.redirect_target, m_target);
      chk("flush_fetch", 32'(bus.flush_fetch), 32'(m_flush_left > 0));
      chk("flush_decode", 32'(bus.flush_decode), 32'(m_flush_left > 0));
      chk("stall_count", bus.stall_count, m_scnt);
      chk("flush_count", bus.flush_count, m_fcnt);
      @(posedge clk);
      m_redir = take;
      if (take) begin
         m_target     = v.target;
         m_flush_left = FC;
         m_stall_left = 0;
         if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
      end else if (m_flush_left > 0) begin
         m_flush_left = m_flush_left - 1;
      end else if (m_stall_left > 0) begin
         m_stall_left = m_stall_left - 1;
      end else if (hz) begin
         m_stall_left = LL - 1;
      end
      if (es && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_t z;
      z = '0;
      for (int i = 0; i < n; i++) step(z);
   endtask

   task automatic do_reset();
      drive('0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst redirect_target", bus.redirect_target, 32'd0);
      chk("rst flush_fetch", 32'(bus.flush_fetch), 32'd0);
      chk("rst stall_count", bus.stall_count, 32'd0);
      chk("rst flush_count", bus.flush_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   vec_t tbl[8];

   initial begin
      in_t hz_v, br_v, both_v, v;
      drive('0);
      drive8('0);
      model_reset();

      // lw x5 in execute, add x6,x5,x7 in decode
      hz_v = fv(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      br_v = '0;
      br_v.ex_valid = 1'b1; br_v.ex_ready = 1'b1; br_v.ex_taken = 1'b1;
      br_v.target = 32'h0000_0100;
      both_v = hz_v;
      both_v.ex_taken = 1'b1; both_v.target = 32'h0000_0440;

      tbl[0] = '{fv(1,5'd3,5'd0,1,1, 1,5'd3,1,0, 1,5'd3,1), 2'd1, 2'd0, 1'b0};
      tbl[1] = '{fv(1,5'd3,5'd0,1,1, 1,5'd3,1,1, 1,5'd3,1), 2'd2, 2'd0, 1'b1};
      tbl[2] = '{fv(1,5'd0,5'd0,1,1, 1,5'd0,1,0, 1,5'd0,1), 2'd0, 2'd0, 1'b0};
      tbl[3] = '{fv(1,5'd5,5'd7,1,1, 1,5'd5,1,1, 1,5'd7,1), 2'd0, 2'd2, 1'b1};
      tbl[4] = '{fv(1,5'd5,5'd7,1,1, 1,5'd0,1,1, 0,5'd0,0), 2'd0, 2'd0, 1'b0};
      tbl[5] = '{fv(1,5'd5,5'd7,0,1, 1,5'd5,1,1, 0,5'd0,0), 2'd0, 2'd0, 1'b0};
      tbl[6] = '{fv(1,5'd4,5'd4,1,1, 0,5'd4,1,0, 0,5'd4,1), 2'd0, 2'd0, 1'b0};
      tbl[7] = '{fv(1,5'd1,5'd9,1,1, 1,5'd9,1,1, 1,5'd1,1), 2'd2, 2'd0, 1'b1};

      @(negedge clk);
      do_reset();

      // Taken branch: redirect one cycle, flush two cycles, flush_count=1.
      step(br_v);
      chk("br redirect_valid", 32'(bus.redirect_valid), 32'd1);
      chk("br redirect_target", bus.redirect_target, 32'h0000_0100);
      chk("br flush_fetch c1", 32'(bus.flush_fetch), 32'd1);
      chk("br flush_count", bus.flush_count, 32'd1);
      idle(1);
      chk("br redirect one cycle", 32'(bus.redirect_valid), 32'd0);
      chk("br flush_decode c2", 32'(bus.flush_decode), 32'd1);
      idle(1);
      chk("br flush ends", 32'(bus.flush_fetch), 32'd0);
      idle(1);

      // Load-use with LOAD_LATENCY=3 from reset: three stall cycles.
      do_reset();
      drive(hz_v); #1;
      chk("lu stall c0", 32'(bus.stall_decode), 32'd1);
      step(hz_v);
      drive('0); #1;
      chk("lu stall c1", 32'(bus.stall_decode), 32'd1);
      idle(2);
      chk("lu stall over", 32'(bus.stall_decode), 32'd0);
      chk("lu stall_count", bus.stall_count, 32'd3);
      idle(1);

      // Table of forwarding / hazard vectors, each followed by a drain.
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].in); #1;
         chk($sformatf("tbl%0d fwd1", i), 32'(bus.fwd_rs1_sel), 32'(tbl[i].f1));
         chk($sformatf("tbl%0d fwd2", i), 32'(bus.fwd_rs2_sel), 32'(tbl[i].f2));
         chk($sformatf("tbl%0d stall", i), 32'(bus.stall_decode), 32'(tbl[i].st));
         step(tbl[i].in);
         idle(4);
      end

      // Branch and load-use hazard together: branch wins.
      drive(both_v); #1;
      chk("both stall", 32'(bus.stall_decode), 32'd0);
      step(both_v);
      chk("both redirect", 32'(bus.redirect_valid), 32'd1);
      chk("both target", bus.redirect_target, 32'h0000_0440);
      idle(3);

      // Branch arriving in STALL preempts it.
      step(hz_v);
      v = br_v; v.target = 32'h0000_0880;
      drive(v); #1;
      chk("stall->br stall", 32'(bus.stall_decode), 32'd0);
      step(v);
      chk("stall->br redirect", 32'(bus.redirect_valid), 32'd1);
      chk("stall->br flush", 32'(bus.flush_fetch), 32'd1);
      drive('0); #1;
      chk("stall->br dropped", 32'(bus.stall_decode), 32'd0);
      idle(3);

      // Taken branch inside FLUSH is wrong-path and ignored.
      step(br_v);
      v = br_v; v.target = 32'h0000_0200;
      step(v);
      chk("flush ignore redirect", 32'(bus.redirect_valid), 32'd0);
      idle(3);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         v = '0;
         v.dec_valid = ($urandom_range(0, 3) != 0);
         v.rs1       = 5'($urandom_range(0, 3));
         v.rs2       = 5'($urandom_range(0, 3));
         v.use1      = 1'($urandom_range(0, 1));
         v.use2      = 1'($urandom_range(0, 1));
         v.ex_valid  = ($urandom_range(0, 3) != 0);
         v.ex_ready  = ($urandom_range(0, 3) != 0);
         v.ex_rd     = 5'($urandom_range(0, 3));
         v.ex_wr     = 1'($urandom_range(0, 1));
         v.ex_load   = 1'($urandom_range(0, 1));
         v.ex_taken  = ($urandom_range(0, 7) == 0);
         v.target    = $urandom;
         v.mem_valid = 1'($urandom_range(0, 1));
         v.mem_rd    = 5'($urandom_range(0, 3));
         v.mem_wr    = 1'($urandom_range(0, 1));
         step(v);
      end

      // Reset in the middle of a flush clears everything asynchronously.
      idle(4);
      step(br_v);
      drive('0);
      rst = 1'b1;
      #1;
      chk("midflush redirect async", 32'(bus.redirect_valid), 32'd0);
      chk("midflush flush async", 32'(bus.flush_fetch), 32'd0);
      chk("midflush target async", bus.redirect_target, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("midflush flush_count", bus.flush_count, 32'd0);
      chk("midflush flush_decode", 32'(bus.flush_decode), 32'd0);
      idle(3);

      // Saturation on the 8-bit instance: continuous load-use stall.
      drive8(hz_v);
      for (int i = 0; i < 254; i++) @(negedge clk);
      chk("sat8 pre", 32'(bus8.stall_count), 32'h0000_00FE);
      @(negedge clk);
      chk("sat8 reach", 32'(bus8.stall_count), 32'h0000_00FF);
      chk("sat8 stalling", 32'(bus8.stall_decode), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("sat8 hold", 32'(bus8.stall_count), 32'h0000_00FF);
      drive8('0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/hazard_flush_controller.md
Name: hazard_flush_controller

Overview:
- Pipeline control block that sequences the decode→execute→memory datapath around the execute stage.
- Detects load-use hazards and stalls decode.
- Turns execute-stage branch/jump resolution into a registered PC redirect plus a multi-cycle flush of the fetch and decode stages.
- Generates operand-forwarding selects for the execute stage and keeps saturating stall and flush event counters for performance debug.

Parameters:
- REGISTER_WIDTH, 32, width of PC, branch target and counters.
- FLUSH_CYCLES, 2, cycles flush_fetch/flush_decode stay high after a taken branch (1..15).
- LOAD_LATENCY, 1, cycles decode must stall on a load-use hazard (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs1  in  5  decode rs1 index.
- dec_rs2  in  5  decode rs2 index.
- dec_uses_rs1  in  1  decode instruction reads rs1.
- dec_uses_rs2  in  1  decode instruction reads rs2.
- ex_valid  in  1  execute tvalid.
- ex_ready  in  1  execute tready.
- ex_rd  in  5  execute destination register.
- ex_reg_write  in  1  execute instruction writes rd.
- ex_is_load  in  1  execute instruction is OPCODE_LOAD.
- ex_branch_taken  in  1  execute branch_taken.
- ex_branch_target  in  REGISTER_WIDTH  execute branch_target.
- mem_valid  in  1  memory stage valid.
- mem_rd  in  5  memory stage destination.
- mem_reg_write  in  1  memory stage writes rd.
- redirect_valid  out  1  one-cycle PC redirect strobe to fetch.
- redirect_target  out  REGISTER_WIDTH  new PC.
- flush_fetch  out  1  squash fetch output.
- flush_decode  out  1  squash decode output.
- stall_decode  out  1  hold decode (deassert decode tready/tvalid toward execute).
- fwd_rs1_sel  out  2  0=regfile, 1=execute result, 2=memory result.
- fwd_rs2_sel  out  2  same encoding for rs2.
- stall_count  out  REGISTER_WIDTH  saturating count of stall cycles.
- flush_count  out  REGISTER_WIDTH  saturating count of taken redirects.

Behaviour:
- Reset (async, any time, including mid-flush or mid-stall):
  - State goes to RUN and all counters clear.
  - redirect_valid, flush_fetch, flush_decode, stall_decode and redirect_target are all 0.
  - fwd selects are combinational and unaffected.
- ex_fire = ex_valid & ex_ready.
- States: RUN, FLUSH, STALL. A 4-bit down-counter cnt is shared between FLUSH and STALL.
- RUN:
  - ex_fire & ex_branch_taken (redirect event):
    - Next cycle: redirect_valid=1 for exactly one cycle, redirect_target=ex_branch_target (registered), flush_fetch=flush_decode=1.
    - State → FLUSH with cnt=FLUSH_CYCLES-1.
    - flush_count increments.
  - Otherwise, on a load-use hazard:
    - Hazard = dec_valid & ex_valid & ex_is_load & ex_reg_write & ex_rd≠0 & ((dec_uses_rs1 & dec_rs1==ex_rd) | (dec_uses_rs2 & dec_rs2==ex_rd)).
    - stall_decode=1 combinationally in the same cycle.
    - If LOAD_LATENCY>1, state → STALL with cnt=LOAD_LATENCY-1.
- FLUSH:
  - flush_fetch=flush_decode=1 and redirect_valid=0.
  - cnt decrements each cycle; at cnt==0 the state returns to RUN (flush total = FLUSH_CYCLES cycles).
  - Hazard detection is masked.
  - A new ex_fire & taken in FLUSH is ignored: the instruction is a squashed wrong-path one.
- STALL:
  - stall_decode=1 and cnt decrements; at cnt==0 the state returns to RUN.
  - If ex_fire & ex_branch_taken occurs in STALL, it preempts the stall: redirect sequence as from RUN, state → FLUSH.
- Priority: a taken branch always wins over a load-use stall in the same cycle; stall_decode is then 0.
- stall_count increments on every cycle with stall_decode=1. Both counters saturate at all-ones and do not wrap.
- Forwarding (combinational, per source operand rs):
  - sel=1 if ex_valid & ex_reg_write & ~ex_is_load & ex_rd≠0 & ex_rd==rs.
  - Else sel=2 if mem_valid & mem_reg_write & mem_rd≠0 & mem_rd==rs.
  - Else 0.
  - Execute wins over memory; x0 is never forwarded.
- No combinational path from ex_branch_target to any output.

Test Plan:
- Reset mid-FLUSH: branch taken at cycle 5, rst at cycle 6 → at cycle 7 all outputs 0, state RUN, flush_count=0.
- Taken branch, FLUSH_CYCLES=2: ex_fire, taken, target 0x0000_0100 at cycle 10 → redirect_valid=1 and target=0x100 at cycle 11 only; flush_fetch/decode high cycles 11–12; flush_count=1.
- Load-use: execute holds lw x5 (valid), decode holds add x6,x5,x7 → stall_decode=1 that cycle; with LOAD_LATENCY=3 it stays high 3 cycles; stall_count=3. The same case with ex_rd=0 → no stall.
- Simultaneous branch and hazard: taken branch plus load-use match in one cycle → stall_decode=0, redirect next cycle. A branch arriving during STALL → FLUSH entered, stall dropped.
- Forwarding priority: ex_rd=mem_rd=3 (both writing, ex not load), dec_rs1=3 → fwd_rs1_sel=1. With ex_is_load=1 → sel=2. With rs2=0 and matching rd=0 → sel=0.
- Saturation: preload by running stalls with REGISTER_WIDTH=8 until stall_count=0xFF → the next stall cycle keeps 0xFF.
